cpu_clock_ctrl: RTL and testbench
=================================

# cpu_clock_ctrl

CPU clock-enable controller running on the 100 MHz board clock, sitting between the board clock/pushbuttons and the single-cycle CPU datapath. It generates a one-cycle `cpu_ce` enable pulse at a programmable divide ratio in free-run mode, or one pulse per debounced button press in single-step mode. It stops issuing enables when the CPU raises `halt`. The CPU advances only on cycles where `cpu_ce` is high; no derived clocks are produced.

## Interface
- `DIV`, default 2: free-run divide ratio, legal range ≥1. `cpu_ce` fires once every `DIV` clocks.
- `DB_CYCLES`, default 1000000: debounce window in clocks (10 ms at 100 MHz), legal range ≥1.
- `clk_100MHz`  in  1  the only clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run_sw`  in  1  asynchronous switch: 1 selects free-run, 0 selects step mode.
- `step_btn`  in  1  asynchronous pushbutton; each press yields one step.
- `halt`  in  1  synchronous level from the CPU; 1 stops enables.
- `cpu_ce`  out  1  registered one-cycle clock-enable to the CPU.
- `ce_count`  out  32  total `cpu_ce` pulses issued; wraps modulo 2^32.
- `state`  out  2  FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
- `running`  out  1  high iff `state`==RUN.

## Operation
- **Reset** forces the following, asynchronously:
  - `state`=IDLE, `cpu_ce`=0, `ce_count`=0, `running`=0.
  - Divider counter=0.
  - All synchronizer, debounce and edge registers=0.
- **Synchronizers:** `run_sw` and `step_btn` each pass through a 2-FF synchronizer, giving `run_s` and `step_s`.
- **Step debounce** (when compiled in):
  - The counter increments while `step_s`≠`db`.
  - When `step_s`≠`db` and the count is `DB_CYCLES`-1, `db`<=`step_s` and the counter clears.
  - The counter clears whenever `step_s`==`db`.
- **Step edge detect:** `step_req` = `db` & ~`db_d`, registered for one cycle. Only rising edges count; release produces no step.
- **FSM transitions:**
  - IDLE: `run_s`=1 → RUN. Else `step_req`=1 and `halt`=0 → STEP. Otherwise stay.
  - RUN: `halt`=1 → HALTED. Else `run_s`=0 → IDLE. Otherwise stay.
  - STEP: `cpu_ce`=1 for exactly this one cycle, then → IDLE unconditionally.
  - HALTED: `run_s`=0 → IDLE; otherwise stay. `halt` deasserting does not resume.
- **Divider:**
  - Counts 0..`DIV`-1 only while in RUN and `halt`=0.
  - At `DIV`-1 it wraps to 0 and `cpu_ce` pulses.
  - It is cleared on every entry into RUN.
  - `DIV`=1 gives `cpu_ce` on every RUN cycle.
- **Simultaneous events:**
  - `halt` beats a due divider pulse: no `cpu_ce` is issued in that cycle.
  - `halt` beats `run_s`=0 in RUN.
  - `step_req` in RUN or HALTED is discarded.
  - `step_req` in IDLE with `halt`=1 is discarded.
- **`ce_count`:** increments by 1 in the same cycle `cpu_ce` is high; 0xFFFFFFFF wraps to 0.
- **Reset mid-operation:** takes effect immediately. A `cpu_ce` pulse in progress is truncated. Any pending debounce count is lost.

## Timing
- `cpu_ce` comes directly from a flop. It is never high for two consecutive cycles unless `DIV`=1 in RUN.
- Latency from `run_sw` rising (sampled at edge N) to `state`=RUN: edge N+2.
- First `cpu_ce` in RUN: `DIV` cycles after the RUN entry edge.
- Latency from a `step_btn` press to `cpu_ce`:
  - 2 cycles (sync) + `DB_CYCLES` (debounce) + 1 (edge register) + 1 (STEP state).
  - Without the debounce feature: 4 cycles.
- `halt` sampled high at edge N: no `cpu_ce` at edge N or later; `state`=HALTED at edge N.
- `ce_count` is updated in the same cycle as `cpu_ce` (zero lag).

## Configuration
- `STEP_DEBOUNCE_EN` defined: the debouncer is instantiated as described.
- `STEP_DEBOUNCE_EN` undefined:
  - `db` = `step_s` directly, and `DB_CYCLES` is ignored.
  - Step latency becomes 4 cycles.
  - Bounce glitches longer than one clock produce multiple steps; this is accepted for simulation and CI.

## Test plan
Unless noted, `DIV`=4 and `DB_CYCLES`=8.
- Reset release, then `run_sw`=1 held 40 cycles → RUN after 2 cycles; `cpu_ce` every 4th cycle; `ce_count`=9 or 10, exactly matching the pulse count.
- `run_sw`=0 with clean `step_btn` pulses (20 cycles high, 20 low, ×3) → exactly 3 `cpu_ce` pulses; each arrives 12 cycles after its press edge; `ce_count`=3.
- With `STEP_DEBOUNCE_EN`: bouncy press (toggles every 3 cycles for 30 cycles, then stable high) → exactly 1 `cpu_ce`.
- In RUN, assert `halt` on the cycle a pulse is due → no `cpu_ce`; `state`=11. Then drop `halt` → still HALTED. Then `run_sw`=0 → IDLE after 2 cycles.
- `DIV`=1 run for 10 cycles → `cpu_ce` continuously high. Preload `ce_count` near 0xFFFFFFFE via force → it wraps to 0 and continues to 1.
- Assert `reset` mid-RUN while `cpu_ce`=1 → `cpu_ce`=0 and `ce_count`=0 in the same cycle; `state`=IDLE, held until `reset` is deasserted.

Source files
------------

// File: rtl/cpu_clock_ctrl_if.sv
// Signal bundle between the board-side inputs, the CPU and cpu_clock_ctrl.
// Handshake: cpu_ce is a one-cycle strobe with no ready/back-pressure; the
// CPU advances exactly once on every rising clk_100MHz edge where cpu_ce is
// high. halt is a level the CPU holds for as long as it wants enables to stop.
interface cpu_clock_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic        halt;
  logic        cpu_ce;
  logic [31:0] ce_count;
  logic [1:0]  state;
  logic        running;

  modport master (
    input  run_sw, step_btn, halt,
    output cpu_ce, ce_count, state, running
  );

  modport slave (
    output run_sw, step_btn, halt,
    input  cpu_ce, ce_count, state, running
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: free-run divider or debounced single-step,
// gated by the CPU's halt level. Produces a one-cycle cpu_ce strobe only.
// Optional feature: define STEP_DEBOUNCE_EN to build the step-button
// debouncer; without it the synchronized button feeds edge detection directly.
module cpu_clock_ctrl #(
  parameter int unsigned DIV       = 2,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input logic             clk_100MHz,
  input logic             reset,
  cpu_clock_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Elaboration-time guard on the legal parameter ranges.
  if (DIV < 1) begin : g_div_check
    $error("cpu_clock_ctrl: DIV must be >= 1");
  end
  if (DB_CYCLES < 1) begin : g_db_check
    $error("cpu_clock_ctrl: DB_CYCLES must be >= 1");
  end

  state_t             state_q, state_d;
  logic               run_meta, run_s;
  logic               step_meta, step_s;
  logic               db, db_d, step_req;
  logic [DIV_W-1:0]   div_q;
  logic               div_due;
  logic               ce_d, cpu_ce_q;
  logic [31:0]        ce_count_q;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      run_meta  <= bus.run_sw;
      run_s     <= run_meta;
      step_meta <= bus.step_btn;
      step_s    <= step_meta;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  logic [DB_W-1:0] db_cnt;

  // Accept a new button level only after it has differed from db for DB_CYCLES clocks.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (step_s == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db     <= step_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  assign db = step_s;
`endif

  // Register a one-cycle step request on each rising edge of the debounced button.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      db_d     <= 1'b0;
      step_req <= 1'b0;
    end else begin
      db_d     <= db;
      step_req <= db & ~db_d;
    end
  end

  assign div_due = (div_q == DIV_W'(DIV - 1));

  // Next-state and enable decode; halt wins over both a due pulse and run_s dropping.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_s) begin
          state_d = RUN;
        end else if (step_req && !bus.halt) begin
          state_d = STEP;
          ce_d    = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else begin
          ce_d = div_due;
          if (!run_s) state_d = IDLE;
        end
      end
      STEP:    state_d = IDLE;
      HALTED:  if (!run_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, enable and pulse-count registers; ce_count moves on the same edge as cpu_ce.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cpu_ce_q   <= 1'b0;
      ce_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_ce_q   <= ce_d;
      ce_count_q <= ce_count_q + {31'd0, ce_d};
    end
  end

  // Free-run divider: cleared on RUN entry, counts only in RUN without halt.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (state_q != RUN && state_d == RUN) begin
      div_q <= '0;
    end else if (state_q == RUN && !bus.halt) begin
      div_q <= div_due ? '0 : div_q + 1'b1;
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.ce_count = ce_count_q;
  assign bus.state    = state_q;
  assign bus.running  = (state_q == RUN);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: DUT A (DIV=4, DB_CYCLES=8) covers run, step,
// bounce, halt and priority cases; DUT B (DIV=1) covers continuous enables,
// ce_count wrap and reset while cpu_ce is high.
`timescale 1ns/1ps
module tb_cpu_clock_ctrl;
  localparam int DIV_A = 4;
  localparam int DB    = 8;
`ifdef STEP_DEBOUNCE_EN
  localparam int STEP_LAT = DB + 4;
`else
  localparam int STEP_LAT = 4;
`endif

  // Clock and reset
  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;
  logic rst_a, rst_b;

  cpu_clock_ctrl_if bus_a ();
  cpu_clock_ctrl_if bus_b ();

  cpu_clock_ctrl #(.DIV(DIV_A), .DB_CYCLES(DB)) u_dut_a (
    .clk_100MHz (clk_100MHz),
    .reset      (rst_a),
    .bus        (bus_a)
  );

  cpu_clock_ctrl #(.DIV(1), .DB_CYCLES(DB)) u_dut_b (
    .clk_100MHz (clk_100MHz),
    .reset      (rst_b),
    .bus        (bus_b)
  );

  // Index of the most recent rising edge.
  logic [31:0] edge_n = '0;
  always @(posedge clk_100MHz) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  // Scoreboard for DUT A: edges on which cpu_ce must be high.
  logic [31:0] exp_q[$];
  logic [31:0] exp_count_a = '0;
  bit          sb_on = 1'b0;

  always @(negedge clk_100MHz) begin : sb_a
    logic exp_ce;
    if (sb_on) begin
      exp_ce = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == edge_n) begin
        exp_ce = 1'b1;
        void'(exp_q.pop_front());
        exp_count_a = exp_count_a + 1;
      end
      total++;
      if (bus_a.cpu_ce !== exp_ce) begin
        bad++;
        $display("FAIL ce_a edge=%0d got=%b exp=%b", edge_n, bus_a.cpu_ce, exp_ce);
      end
    end
  end

  // Advance n falling edges, then settle 1ns so the scoreboard has run.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.run_sw = 1'b0; bus_a.step_btn = 1'b0; bus_a.halt = 1'b0;
    bus_b.run_sw = 1'b0; bus_b.step_btn = 1'b0; bus_b.halt = 1'b0;
    wait_cyc(3);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL rst_state_a got=%b exp=00", bus_a.state); end
    total++; if (bus_a.cpu_ce !== 1'b0) begin bad++; $display("FAIL rst_ce_a got=%b exp=0", bus_a.cpu_ce); end
    total++; if (bus_a.ce_count !== 32'd0) begin bad++; $display("FAIL rst_count_a got=%0d exp=0", bus_a.ce_count); end
    total++; if (bus_a.running !== 1'b0) begin bad++; $display("FAIL rst_running_a got=%b exp=0", bus_a.running); end
    total++; if (bus_b.state !== 2'b00 || bus_b.cpu_ce !== 1'b0 || bus_b.ce_count !== 32'd0)
      begin bad++; $display("FAIL rst_b state=%b ce=%b count=%0d exp 00/0/0", bus_b.state, bus_b.cpu_ce, bus_b.ce_count); end
    rst_a = 1'b0; rst_b = 1'b0;
    wait_cyc(3);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL post_rst_state_a got=%b exp=00", bus_a.state); end
    sb_on = 1'b1;
  endtask

  task automatic test_run();
    int l;
    logic [31:0] e0, ent;
    l   = $urandom_range(40, 48);
    e0  = edge_n;
    ent = e0 + 3;
    for (int k = 1; k * DIV_A <= l; k++) exp_q.push_back(ent + 32'(k * DIV_A));
    bus_a.run_sw = 1'b1;
    wait_cyc(2);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL run_early_state got=%b exp=00", bus_a.state); end
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b01 || bus_a.running !== 1'b1)
      begin bad++; $display("FAIL run_entry state=%b running=%b exp=01/1", bus_a.state, bus_a.running); end
    wait_cyc(l - 3);
    bus_a.run_sw = 1'b0;
    wait_cyc(2);
    total++; if (bus_a.state !== 2'b01) begin bad++; $display("FAIL run_exit_early got=%b exp=01", bus_a.state); end
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b00 || bus_a.running !== 1'b0)
      begin bad++; $display("FAIL run_exit state=%b running=%b exp=00/0", bus_a.state, bus_a.running); end
    wait_cyc(DIV_A + 2);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL run_pending got=%0d exp=0", exp_q.size()); end
    total++; if (bus_a.ce_count !== 32'(l / DIV_A))
      begin bad++; $display("FAIL run_count got=%0d exp=%0d", bus_a.ce_count, l / DIV_A); end
  endtask

  task automatic test_step();
    int h, l;
    for (int i = 0; i < 3; i++) begin
      h = $urandom_range(16, 24);
      l = $urandom_range(16, 24);
      exp_q.push_back(edge_n + 32'(STEP_LAT));
      bus_a.step_btn = 1'b1;
      wait_cyc(STEP_LAT);
      total++; if (bus_a.state !== 2'b10) begin bad++; $display("FAIL step_state press=%0d got=%b exp=10", i, bus_a.state); end
      wait_cyc(1);
      total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL step_return press=%0d got=%b exp=00", i, bus_a.state); end
      wait_cyc(h - STEP_LAT - 1);
      bus_a.step_btn = 1'b0;
      wait_cyc(l);
    end
    wait_cyc(4);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL step_pending got=%0d exp=0", exp_q.size()); end
    total++; if (bus_a.ce_count !== exp_count_a)
      begin bad++; $display("FAIL step_count got=%0d exp=%0d", bus_a.ce_count, exp_count_a); end
  endtask

`ifdef STEP_DEBOUNCE_EN
  task automatic test_bounce();
    int per;
    per = $urandom_range(2, 5);
    for (int s = 0; s < 10; s++) begin
      bus_a.step_btn = (s % 2 == 0);
      wait_cyc(per);
    end
    exp_q.push_back(edge_n + 32'(STEP_LAT));
    bus_a.step_btn = 1'b1;
    wait_cyc(STEP_LAT + 8);
    bus_a.step_btn = 1'b0;
    wait_cyc(DB + 8);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bounce_pending got=%0d exp=0", exp_q.size()); end
    total++; if (bus_a.ce_count !== exp_count_a)
      begin bad++; $display("FAIL bounce_count got=%0d exp=%0d", bus_a.ce_count, exp_count_a); end
  endtask
`endif

  task automatic test_halt();
    int k, d;
    logic [31:0] e0, ent, due, r;
    // Halt lands on the edge a pulse is due.
    k   = $urandom_range(2, 4);
    e0  = edge_n;
    ent = e0 + 3;
    due = ent + 32'(k * DIV_A);
    for (int j = 1; j < k; j++) exp_q.push_back(ent + 32'(j * DIV_A));
    bus_a.run_sw = 1'b1;
    wait_cyc(int'(due - e0) - 1);
    bus_a.halt = 1'b1;
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b11 || bus_a.running !== 1'b0)
      begin bad++; $display("FAIL halt_enter state=%b running=%b exp=11/0", bus_a.state, bus_a.running); end
    wait_cyc(3);
    bus_a.halt = 1'b0;
    d = $urandom_range(5, 10);
    wait_cyc(d);
    total++; if (bus_a.state !== 2'b11) begin bad++; $display("FAIL halt_sticky got=%b exp=11", bus_a.state); end
    // Step press while halted is discarded.
    bus_a.step_btn = 1'b1;
    wait_cyc(STEP_LAT + 4);
    bus_a.step_btn = 1'b0;
    wait_cyc(DB + 6);
    total++; if (bus_a.state !== 2'b11) begin bad++; $display("FAIL halt_step got=%b exp=11", bus_a.state); end
    bus_a.run_sw = 1'b0;
    wait_cyc(2);
    total++; if (bus_a.state !== 2'b11) begin bad++; $display("FAIL halt_exit_early got=%b exp=11", bus_a.state); end
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL halt_exit got=%b exp=00", bus_a.state); end

    // Step request in IDLE while halt is high is discarded.
    bus_a.halt = 1'b1;
    bus_a.step_btn = 1'b1;
    wait_cyc(STEP_LAT + 4);
    bus_a.step_btn = 1'b0;
    wait_cyc(DB + 6);
    bus_a.halt = 1'b0;
    wait_cyc(4);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL idle_halt_step got=%b exp=00", bus_a.state); end

    // halt and run_s falling on the same edge: halt wins.
    e0  = edge_n;
    ent = e0 + 3;
    r   = ent + 32'($urandom_range(3, 9));
    for (int j = 1; ent + 32'(j * DIV_A) < r + 2; j++) exp_q.push_back(ent + 32'(j * DIV_A));
    bus_a.run_sw = 1'b1;
    wait_cyc(int'(r - e0));
    bus_a.run_sw = 1'b0;
    wait_cyc(1);
    bus_a.halt = 1'b1;
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b11) begin bad++; $display("FAIL halt_vs_run got=%b exp=11", bus_a.state); end
    bus_a.halt = 1'b0;
    wait_cyc(1);
    total++; if (bus_a.state !== 2'b00) begin bad++; $display("FAIL halt_vs_run_exit got=%b exp=00", bus_a.state); end
    wait_cyc(4);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_pending got=%0d exp=0", exp_q.size()); end
    total++; if (bus_a.ce_count !== exp_count_a)
      begin bad++; $display("FAIL halt_count got=%0d exp=%0d", bus_a.ce_count, exp_count_a); end
  endtask

  task automatic test_div1_wrap_reset();
    logic [31:0] exp_b;
    bus_b.run_sw = 1'b1;
    wait_cyc(3);
    total++; if (bus_b.state !== 2'b01 || bus_b.cpu_ce !== 1'b0)
      begin bad++; $display("FAIL div1_entry state=%b ce=%b exp=01/0", bus_b.state, bus_b.cpu_ce); end
    for (int i = 1; i <= 10; i++) begin
      wait_cyc(1);
      total++; if (bus_b.cpu_ce !== 1'b1 || bus_b.ce_count !== 32'(i))
        begin bad++; $display("FAIL div1_run cyc=%0d ce=%b count=%0d exp=1/%0d", i, bus_b.cpu_ce, bus_b.ce_count, i); end
    end
    force u_dut_b.ce_count_q = 32'hFFFF_FFFE;
    #1;
    release u_dut_b.ce_count_q;
    exp_b = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      exp_b = exp_b + 32'd1;
      total++; if (bus_b.ce_count !== exp_b)
        begin bad++; $display("FAIL wrap_count step=%0d got=%h exp=%h", i, bus_b.ce_count, exp_b); end
    end
    total++; if (bus_b.cpu_ce !== 1'b1) begin bad++; $display("FAIL pre_reset_ce got=%b exp=1", bus_b.cpu_ce); end
    rst_b = 1'b1;
    #1;
    total++; if (bus_b.cpu_ce !== 1'b0 || bus_b.ce_count !== 32'd0 || bus_b.state !== 2'b00)
      begin bad++; $display("FAIL mid_reset ce=%b count=%0d state=%b exp=0/0/00", bus_b.cpu_ce, bus_b.ce_count, bus_b.state); end
    wait_cyc(3);
    total++; if (bus_b.state !== 2'b00 || bus_b.cpu_ce !== 1'b0)
      begin bad++; $display("FAIL reset_hold state=%b ce=%b exp=00/0", bus_b.state, bus_b.cpu_ce); end
    bus_b.run_sw = 1'b0;
    rst_b = 1'b0;
    wait_cyc(3);
    total++; if (bus_b.state !== 2'b00) begin bad++; $display("FAIL post_mid_reset got=%b exp=00", bus_b.state); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
`ifdef STEP_DEBOUNCE_EN
    test_bounce();
`endif
    test_halt();
    test_div1_wrap_reset();
    sb_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
